// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared state type and card constants for the card draw arbiter
package card_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_GAP_WAIT, ST_DRAW, ST_ACK} state_t;

    localparam int CARD_MIN = 1;
    localparam int CARD_MAX = 10;
    localparam int FACE_MAX = 13;
    localparam int CNT_W    = 6;
endpackage

// File: rtl/card_draw_arbiter_if.sv
// rtl/card_draw_arbiter_if.sv - request/ack/card bus between players and the arbiter
interface card_draw_arbiter_if;
    logic                       req_p;
    logic                       req_d;
    logic                       new_round;
    logic                       ack_p;
    logic                       ack_d;
    logic [3:0]                 card;
    logic                       busy;
    logic [card_pkg::CNT_W-1:0] draw_cnt;

    modport master (output req_p, req_d, new_round,
                    input  ack_p, ack_d, card, busy, draw_cnt);
    modport slave  (input  req_p, req_d, new_round,
                    output ack_p, ack_d, card, busy, draw_cnt);
endinterface

// File: rtl/randomnum_intf.sv
// rtl/randomnum_intf.sv - free-running random value feed from randomnum
interface randomnum_intf #(parameter int N = 4);
    logic [N-1:0] rnd;

    modport master (output rnd);
    modport slave  (input  rnd);
endinterface

// File: rtl/card_draw_arbiter_map.sv
// rtl/card_draw_arbiter_map.sv - raw random value to card mapping with reject decision
module card_map
    import card_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_rnd,
    output logic [3:0]   o_card,
    output logic         o_reject
);
    logic [31:0] w_raw;

    assign w_raw = 32'(i_rnd);

    // Faces J/Q/K fold to 10; values outside 1..13 would bias the deck and are redrawn.
    always_comb begin
        o_card   = 4'd0;
        o_reject = 1'b0;
        if (w_raw < 32'(CARD_MIN) || w_raw > 32'(FACE_MAX)) begin
            o_reject = 1'b1;
        end else if (w_raw > 32'(CARD_MAX)) begin
            o_card = 4'(CARD_MAX);
        end else begin
            o_card = w_raw[3:0];
        end
    end
endmodule

// File: rtl/card_draw_arbiter.sv
// rtl/card_draw_arbiter.sv - round-robin player/dealer card draw arbiter with reject retry and gap
module card_draw_arbiter
    import card_pkg::*;
#(
    parameter int N       = 4,
    parameter int GAP     = 3,
    parameter int MAX_REJ = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    randomnum_intf.slave        rng,
    card_draw_arbiter_if.slave  bus
);
    state_t             r_state;
    state_t             w_next;
    logic               r_win_d;
    logic               r_last_d;
    logic [3:0]         r_gap;
    logic [7:0]         r_rej;
    logic               r_ack_p;
    logic               r_ack_d;
    logic [3:0]         r_card;
    logic [CNT_W-1:0]   r_cnt;

    logic [3:0]         w_map_card;
    logic               w_reject;
    logic               w_force;
    logic               w_accept;
    logic               w_pick_d;
    logic [3:0]         w_card_sel;

    card_map #(.N(N)) u_map (
        .i_rnd    (rng.rnd),
        .o_card   (w_map_card),
        .o_reject (w_reject)
    );

    always_comb begin
        w_next     = r_state;
        w_pick_d   = bus.req_d && (!bus.req_p || !r_last_d);
        w_force    = w_reject && (({24'd0, r_rej} + 32'd1) >= 32'(MAX_REJ));
        w_accept   = !w_reject || w_force;
        w_card_sel = w_reject ? 4'(CARD_MAX) : w_map_card;
        case (r_state)
            ST_IDLE:     if (bus.req_p || bus.req_d) w_next = ST_DRAW;
            ST_DRAW:     if (w_accept) w_next = ST_ACK;
            ST_ACK:      w_next = (GAP == 0) ? ST_IDLE : ST_GAP_WAIT;
            ST_GAP_WAIT: if (r_gap <= 4'd1) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_win_d  <= 1'b0;
            r_last_d <= 1'b1;
            r_gap    <= 4'd0;
            r_rej    <= 8'd0;
            r_ack_p  <= 1'b0;
            r_ack_d  <= 1'b0;
            r_card   <= 4'd0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            r_ack_p <= 1'b0;
            r_ack_d <= 1'b0;
            r_card  <= 4'd0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_p || bus.req_d) r_win_d <= w_pick_d;
                end
                ST_DRAW: begin
                    if (w_accept) begin
                        r_rej   <= 8'd0;
                        r_ack_p <= !r_win_d;
                        r_ack_d <= r_win_d;
                        r_card  <= w_card_sel;
                    end else begin
                        r_rej <= r_rej + 8'd1;
                    end
                end
                ST_ACK: begin
                    r_gap    <= 4'(GAP);
                    r_last_d <= r_win_d;
                    if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                end
                ST_GAP_WAIT: r_gap <= r_gap - 4'd1;
                default: ;
            endcase
            // Placed last so a new round overrides both the count and the priority update of a same-cycle ack.
            if (bus.new_round) begin
                r_last_d <= 1'b1;
                r_cnt    <= '0;
            end
        end
    end

    assign bus.ack_p    = r_ack_p;
    assign bus.ack_d    = r_ack_d;
    assign bus.card     = r_card;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.draw_cnt = r_cnt;
endmodule

// File: doc/card_draw_arbiter.md
CARD_DRAW_ARBITER -- requirements
Module: card_draw_arbiter

Interface
REQ-001 Parameter N, default 4: width of the raw random value.
REQ-002 Parameter GAP, default 3: minimum idle cycles between consecutive draws (range 0..15).
REQ-003 Parameter MAX_REJ, default 8: consecutive rejected samples before a forced card.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rnd  in  N  free-running value from randomnum.
REQ-007 req_p  in  1  player card request; level, held until ack_p.
REQ-008 req_d  in  1  dealer card request; level, held until ack_d.
REQ-009 new_round  in  1  one-cycle pulse; clears draw count and priority.
REQ-010 ack_p  out  1  one-cycle pulse: card valid for player.
REQ-011 ack_d  out  1  one-cycle pulse: card valid for dealer.
REQ-012 card  out  4  card value 1..10, valid only in the ack cycle.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 draw_cnt  out  6  cards dealt this round, saturating at 63.

Function
REQ-015 FSM states: IDLE, GAP_WAIT, DRAW, ACK.
REQ-016 IDLE: any request -> latch winner, go DRAW; no request -> stay.
REQ-017 Arbitration: round-robin; on a tie, the requester not served last wins; after reset or new_round, player wins.
REQ-018 DRAW: sample rnd; raw 1..10 -> card = raw; raw 11..13 -> card = 10; raw 0, 14 or 15 -> reject, stay in DRAW, increment reject count.
REQ-019 Reject count reaching MAX_REJ forces card = 10 on that cycle; the count clears on every accept.
REQ-020 Accept -> ACK: assert exactly one ack for the latched winner; card is held stable for that cycle.
REQ-021 ACK -> GAP_WAIT with gap counter loaded to GAP; GAP = 0 -> go straight to IDLE.
REQ-022 GAP_WAIT decrements each cycle and goes to IDLE when the counter reaches 0; requests are ignored during GAP_WAIT.
REQ-023 Latency: with no rejects, ack rises 2 cycles after req is sampled in IDLE.
REQ-024 A request dropped before its ack is still served; the ack is issued anyway, and the requester ignores it.
REQ-025 draw_cnt increments on each ack and saturates at 63 (no wrap).
REQ-026 new_round and an ack in the same cycle: draw_cnt becomes 0; the ack still completes.
REQ-027 new_round does not abort an in-flight draw.
REQ-028 ack_p and ack_d are never high in the same cycle.
REQ-029 card = 0 outside ack cycles.

Reset
REQ-030 On rst: state IDLE; ack_p = ack_d = 0; card = 0; busy = 0; draw_cnt = 0; reject and gap counters = 0; priority = player.
REQ-031 rst mid-draw discards the draw; no ack is issued in or after the reset cycle.

Structure
REQ-032 The state enum, card constants (CARD_MIN = 1, CARD_MAX = 10, FACE_MAX = 13) and the draw_cnt width live in the shared package card_pkg.
REQ-033 Raw-to-card mapping and the reject decision are a combinational sub-module card_map (rnd in; card and reject out).
REQ-034 The block connects to randomnum through the existing randomnum_intf modport; no change to randomnum.

Verification
REQ-035 Player req only, rnd = 7 -> ack_p 2 cycles later, card = 7, draw_cnt = 1.
REQ-036 rnd = 12 at sample -> card = 10; rnd = 0, 15, 14 then 5 -> 3 reject cycles, then card = 5.
REQ-037 rnd stuck at 0 -> ack after exactly MAX_REJ = 8 reject cycles with card = 10.
REQ-038 Both reqs held continuously, GAP = 3 -> acks alternate P, D, P, D; ack-to-next-ack spacing is 6 cycles; never simultaneous.
REQ-039 rst asserted in DRAW -> no ack; all outputs at reset values next cycle; a held req is served afresh with player priority.
REQ-040 64 draws -> draw_cnt holds 63; new_round coincident with an ack -> draw_cnt = 0 and the ack is still seen.
